vector_regfile_pipe: RTL and testbench

//  Parametrised 2-read/1-write vector register file for the decode stage.

---
 rtl/vrf_pkg.sv | 16 +
 rtl/vector_regfile_pipe_if.sv | 34 +++
 rtl/vrf_lane_bank.sv | 41 ++++
 rtl/vector_regfile_pipe.sv | 139 +++++++++++++
 tb/tb_vector_regfile_pipe.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/vrf_pkg.sv
// Shared types and default geometry for the decode-stage vector register file.
package vrf_pkg;

    localparam int VRF_NUM_LANES  = 4;
    localparam int VRF_LANE_WIDTH = 32;
    localparam int VRF_NUM_REGS   = 32;

    typedef logic [VRF_LANE_WIDTH-1:0] lane_t;
    typedef lane_t [VRF_NUM_LANES-1:0] vec_t;

    typedef enum logic [0:0] {
        VRF_CLEAR = 1'b0,
        VRF_RUN   = 1'b1
    } vrf_state_e;

endpackage

// File: rtl/vector_regfile_pipe_if.sv
// Read/write bus of the vector register file; master drives requests, slave returns data.
interface vector_regfile_pipe_if
    import vrf_pkg::*;
#(
    parameter  int NUM_LANES  = VRF_NUM_LANES,
    parameter  int LANE_WIDTH = VRF_LANE_WIDTH,
    parameter  int NUM_REGS   = VRF_NUM_REGS,
    localparam int AW         = $clog2(NUM_REGS),
    localparam int VW         = NUM_LANES * LANE_WIDTH
);

    logic                 re1;
    logic [AW-1:0]        raddr1;
    logic                 re2;
    logic [AW-1:0]        raddr2;
    logic [NUM_LANES-1:0] we_mask;
    logic [AW-1:0]        waddr;
    logic [VW-1:0]        wdata;
    logic                 wbcast;
    logic [VW-1:0]        rdata1;
    logic [VW-1:0]        rdata2;
    logic                 ready;

    modport master (
        output re1, raddr1, re2, raddr2, we_mask, waddr, wdata, wbcast,
        input  rdata1, rdata2, ready
    );

    modport slave (
        input  re1, raddr1, re2, raddr2, we_mask, waddr, wdata, wbcast,
        output rdata1, rdata2, ready
    );

endinterface

// File: rtl/vrf_lane_bank.sv
// Storage for one lane: NUM_REGS entries, one write port, two registered read ports.
module vrf_lane_bank #(
    parameter  int LANE_WIDTH = 32,
    parameter  int NUM_REGS   = 32,
    localparam int AW         = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [LANE_WIDTH-1:0] wdata,
    input  logic                  re1,
    input  logic [AW-1:0]         raddr1,
    output logic [LANE_WIDTH-1:0] rdata1,
    input  logic                  re2,
    input  logic [AW-1:0]         raddr2,
    output logic [LANE_WIDTH-1:0] rdata2
);

    logic [LANE_WIDTH-1:0] mem [NUM_REGS];
    logic [LANE_WIDTH-1:0] rdata1_d, rdata1_q;
    logic [LANE_WIDTH-1:0] rdata2_d, rdata2_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_comb begin
        rdata1_d = re1 ? mem[raddr1] : rdata1_q;
        rdata2_d = re2 ? mem[raddr2] : rdata2_q;
    end

    // Unreset on purpose: the top masks these until a valid read has been captured.
    always_ff @(posedge clk) begin
        rdata1_q <= rdata1_d;
        rdata2_q <= rdata2_d;
    end

    assign rdata1 = rdata1_q;
    assign rdata2 = rdata2_q;

endmodule

// File: rtl/vector_regfile_pipe.sv
// 2R/1W vector register file: per-lane banks, write forwarding, broadcast write, post-reset clear.
module vector_regfile_pipe
    import vrf_pkg::*;
#(
    parameter  int NUM_LANES  = VRF_NUM_LANES,
    parameter  int LANE_WIDTH = VRF_LANE_WIDTH,
    parameter  int NUM_REGS   = VRF_NUM_REGS,
    localparam int AW         = $clog2(NUM_REGS),
    localparam int VW         = NUM_LANES * LANE_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vector_regfile_pipe_if.slave bus
);

    localparam logic [AW:0]   REGS_N    = (AW + 1)'(NUM_REGS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_REGS - 1);

    vrf_state_e           state_d, state_q;
    logic [AW-1:0]        clr_addr_d, clr_addr_q;
    logic                 run;
    logic                 waddr_ok;
    logic [VW-1:0]        wdata_eff;
    logic [NUM_LANES-1:0] bank_we;
    logic [AW-1:0]        bank_waddr;
    logic [VW-1:0]        bank_wdata;

    logic [1:0]                re;
    logic [1:0][AW-1:0]        raddr;
    logic [1:0]                rd_en;
    logic [1:0][VW-1:0]        bank_rd;
    logic [1:0]                rd_zero_d, rd_zero_q;
    logic [1:0][NUM_LANES-1:0] fwd_mask_d, fwd_mask_q;
    logic [1:0][VW-1:0]        fwd_data_d, fwd_data_q;
    logic [1:0][VW-1:0]        rdata_out;

    assign run      = (state_q == VRF_RUN);
    assign waddr_ok = ({1'b0, bus.waddr} < REGS_N);
    assign re       = {bus.re2, bus.re1};
    assign raddr    = {bus.raddr2, bus.raddr1};

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == VRF_CLEAR) begin
            clr_addr_d = clr_addr_q + AW'(1);
            if (clr_addr_q == LAST_ADDR) state_d = VRF_RUN;
        end
    end

    always_comb begin
        wdata_eff = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            wdata_eff[l*LANE_WIDTH +: LANE_WIDTH] = bus.wbcast ? bus.wdata[LANE_WIDTH-1:0]
                                                               : bus.wdata[l*LANE_WIDTH +: LANE_WIDTH];
        end
    end

    // The clear sequencer owns the write port until every register is zeroed.
    always_comb begin
        if (run) begin
            bank_we    = bus.we_mask & {NUM_LANES{waddr_ok}};
            bank_waddr = bus.waddr;
            bank_wdata = wdata_eff;
        end else begin
            bank_we    = '1;
            bank_waddr = clr_addr_q;
            bank_wdata = '0;
        end
    end

    always_comb begin
        rd_zero_d  = rd_zero_q;
        fwd_mask_d = fwd_mask_q;
        fwd_data_d = fwd_data_q;
        rd_en      = '0;
        for (int p = 0; p < 2; p++) begin
            if (re[p] && run) begin
                rd_en[p]      = 1'b1;
                rd_zero_d[p]  = !({1'b0, raddr[p]} < REGS_N);
                fwd_mask_d[p] = (raddr[p] == bus.waddr) ? bus.we_mask : '0;
                fwd_data_d[p] = wdata_eff;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= VRF_CLEAR;
            clr_addr_q <= '0;
            rd_zero_q  <= '1;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            rd_zero_q  <= rd_zero_d;
            fwd_mask_q <= fwd_mask_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        vrf_lane_bank #(
            .LANE_WIDTH (LANE_WIDTH),
            .NUM_REGS   (NUM_REGS)
        ) u_bank (
            .clk    (clk),
            .we     (bank_we[l]),
            .waddr  (bank_waddr),
            .wdata  (bank_wdata[l*LANE_WIDTH +: LANE_WIDTH]),
            .re1    (rd_en[0]),
            .raddr1 (raddr[0]),
            .rdata1 (bank_rd[0][l*LANE_WIDTH +: LANE_WIDTH]),
            .re2    (rd_en[1]),
            .raddr2 (raddr[1]),
            .rdata2 (bank_rd[1][l*LANE_WIDTH +: LANE_WIDTH])
        );
    end

    always_comb begin
        rdata_out = '0;
        for (int p = 0; p < 2; p++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (rd_zero_q[p])
                    rdata_out[p][l*LANE_WIDTH +: LANE_WIDTH] = '0;
                else if (fwd_mask_q[p][l])
                    rdata_out[p][l*LANE_WIDTH +: LANE_WIDTH] = fwd_data_q[p][l*LANE_WIDTH +: LANE_WIDTH];
                else
                    rdata_out[p][l*LANE_WIDTH +: LANE_WIDTH] = bank_rd[p][l*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    assign bus.rdata1 = rdata_out[0];
    assign bus.rdata2 = rdata_out[1];
    assign bus.ready  = run;

endmodule

// File: tb/tb_vector_regfile_pipe.sv
// Scoreboard bench: stimulus pushes predicted outputs, a monitor pops and compares every cycle.
module tb_vector_regfile_pipe;
    import vrf_pkg::*;

    localparam int NREGS = 32;

    typedef struct {
        logic ready;
        vec_t rd1;
        vec_t rd2;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vector_regfile_pipe_if #(.NUM_LANES(4), .LANE_WIDTH(32), .NUM_REGS(NREGS)) bus ();

    vector_regfile_pipe #(.NUM_LANES(4), .LANE_WIDTH(32), .NUM_REGS(NREGS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    // Reference model: register contents, remaining clear cycles, held read values.
    vec_t ref_mem [NREGS];
    int   clr_left;
    vec_t hold1, hold2;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("ready",  {127'd0, bus.ready}, {127'd0, e.ready});
                chk("rdata1", bus.rdata1, e.rd1);
                chk("rdata2", bus.rdata2, e.rd2);
            end
        end
    end

    // Called at a negedge; drives one cycle and returns at the next negedge.
    task automatic drive_cycle(input logic re1, input logic [4:0] ra1,
                               input logic re2, input logic [4:0] ra2,
                               input logic [3:0] mask, input logic [4:0] wa,
                               input vec_t wd, input logic bc);
        exp_t e;
        bus.re1 = re1;  bus.raddr1 = ra1;
        bus.re2 = re2;  bus.raddr2 = ra2;
        bus.we_mask = mask; bus.waddr = wa;
        bus.wdata = wd; bus.wbcast = bc;
        if (clr_left == 0) begin
            // Applying the write before the read gives read-after-write forwarding.
            for (int l = 0; l < 4; l++)
                if (mask[l]) ref_mem[wa][l] = bc ? wd[0] : wd[l];
            if (re1) hold1 = ref_mem[ra1];
            if (re2) hold2 = ref_mem[ra2];
        end else begin
            clr_left--;
        end
        e.ready = (clr_left == 0);
        e.rd1   = hold1;
        e.rd2   = hold2;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        drive_cycle(1'b0, 5'd0, 1'b0, 5'd0, 4'h0, 5'd0, '0, 1'b0);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int l = 0; l < 4; l++) v[l] = $urandom;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_rdata1", bus.rdata1, '0);
        chk("rst_rdata2", bus.rdata2, '0);
        chk("rst_ready",  {127'd0, bus.ready}, '0);
        for (int r = 0; r < NREGS; r++) ref_mem[r] = '0;
        clr_left = NREGS;
        hold1 = '0;
        hold2 = '0;
        bus.re1 = 0; bus.re2 = 0; bus.we_mask = 0; bus.wbcast = 0;
        bus.raddr1 = 0; bus.raddr2 = 0; bus.waddr = 0; bus.wdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive_cycle($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                        $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                        4'($urandom_range(0, 15)), 5'($urandom_range(0, 7)),
                        rand_vec(), $urandom_range(0, 3) == 0);
        end
    endtask

    task automatic clear_with_writes(input int n);
        for (int i = 0; i < n; i++)
            drive_cycle(1'b1, 5'd9, 1'b1, 5'd9, 4'hF, 5'd9, rand_vec(), 1'b0);
    endtask

    task automatic read_all();
        for (int r = 0; r < NREGS; r++)
            drive_cycle(1'b1, 5'(r), 1'b1, 5'(NREGS - 1 - r), 4'h0, 5'd0, '0, 1'b0);
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        bus.re1 = 0; bus.re2 = 0; bus.we_mask = 0; bus.wbcast = 0;
        bus.raddr1 = 0; bus.raddr2 = 0; bus.waddr = 0; bus.wdata = '0;

        do_reset();
        clear_with_writes(NREGS);
        read_all();

        v[3] = 32'hD; v[2] = 32'hC; v[1] = 32'hB; v[0] = 32'hA;
        drive_cycle(1'b0, 5'd0, 1'b0, 5'd0, 4'hF, 5'd5, v, 1'b0);
        drive_cycle(1'b1, 5'd5, 1'b0, 5'd0, 4'h0, 5'd0, '0, 1'b0);

        v[3] = 32'h11; v[2] = 32'h22; v[1] = 32'h33; v[0] = 32'h44;
        drive_cycle(1'b0, 5'd0, 1'b0, 5'd0, 4'hF, 5'd7, v, 1'b0);
        v[3] = 32'hEE; v[2] = 32'h2; v[1] = 32'hEE; v[0] = 32'h0;
        drive_cycle(1'b1, 5'd7, 1'b1, 5'd7, 4'b0101, 5'd7, v, 1'b0);

        v[3] = 32'h1111; v[2] = 32'h2222; v[1] = 32'h3333; v[0] = 32'hCAFE;
        drive_cycle(1'b0, 5'd0, 1'b0, 5'd0, 4'b1010, 5'd3, v, 1'b1);
        drive_cycle(1'b1, 5'd3, 1'b1, 5'd5, 4'h0, 5'd0, '0, 1'b0);
        idle(); idle(); idle();

        random_cycles(300);

        do_reset();
        clear_with_writes(10);
        do_reset();
        clear_with_writes(NREGS);
        read_all();
        random_cycles(100);

        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
